// File: rtl/data_cache_pkg.sv
// Shared widths, FSM state encoding and address helpers for the direct-mapped data cache.
package data_cache_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned NUM_BLOCKS  = 8;
  localparam int unsigned BLOCK_BYTES = 4;
  localparam int unsigned INDEX_W     = $clog2(NUM_BLOCKS);
  localparam int unsigned OFFSET_W    = $clog2(BLOCK_BYTES);
  localparam int unsigned TAG_W       = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [2:0] {
    IDLE,
    WB_ACCESS,
    WB_GAP,
    FILL_ACCESS,
    FILL_GAP
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_fields_t;

  function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] a);
    return addr_fields_t'(a);
  endfunction

  function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0]    t,
                                                   input logic [INDEX_W-1:0]  i,
                                                   input logic [OFFSET_W-1:0] o);
    return {t, i, o};
  endfunction

endpackage

// File: rtl/data_cache_mem_ctrl.sv
// Byte-serial memory sequencer: access/gap pairs for write-back followed by fill.
module cache_mem_ctrl
  import data_cache_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_miss,
  input  logic                i_need_wb,
  input  logic                i_mem_busywait,
  output state_t              o_state,
  output logic [OFFSET_W-1:0] o_count
);

  state_t              r_state;
  logic [OFFSET_W-1:0] r_count;
  logic                w_last;

  assign w_last  = (r_count == OFFSET_W'(BLOCK_BYTES - 1));
  assign o_state = r_state;
  assign o_count = r_count;

  // The gap state drops the strobes for one cycle so the memory sees a fresh request.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (i_miss) r_state <= i_need_wb ? WB_ACCESS : FILL_ACCESS;
        end
        WB_ACCESS: begin
          if (!i_mem_busywait) r_state <= WB_GAP;
        end
        WB_GAP: begin
          r_count <= r_count + OFFSET_W'(1);
          r_state <= w_last ? FILL_ACCESS : WB_ACCESS;
        end
        FILL_ACCESS: begin
          if (!i_mem_busywait) r_state <= FILL_GAP;
        end
        FILL_GAP: begin
          r_count <= r_count + OFFSET_W'(1);
          r_state <= w_last ? IDLE : FILL_ACCESS;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate cache between the CPU and the byte-wide data memory.
module data_cache
  import data_cache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  logic [DATA_W-1:0]     r_data [NUM_BLOCKS][BLOCK_BYTES];
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;

  addr_fields_t          w_addr;
  state_t                w_state;
  logic [OFFSET_W-1:0]   w_count;
  logic                  w_access, w_hit, w_idle, w_miss, w_need_wb;
  logic                  w_fill_we, w_fill_done, w_write_hit, w_read_hit;

  assign w_addr      = split_addr(address);
  assign w_access    = read ^ write;
  assign w_hit       = r_valid[w_addr.index] && (r_tag[w_addr.index] == w_addr.tag);
  assign w_idle      = (w_state == IDLE);
  assign w_miss      = w_idle && w_access && !w_hit;
  assign w_need_wb   = r_valid[w_addr.index] && r_dirty[w_addr.index];
  assign w_read_hit  = w_idle && read && !write && w_hit;
  assign w_write_hit = w_idle && write && !read && w_hit;
  assign w_fill_we   = (w_state == FILL_ACCESS) && !mem_busywait;
  assign w_fill_done = (w_state == FILL_GAP) && (w_count == OFFSET_W'(BLOCK_BYTES - 1));

  cache_mem_ctrl u_mem_ctrl (
    .i_clk          (clock),
    .i_reset        (reset),
    .i_miss         (w_miss),
    .i_need_wb      (w_need_wb),
    .i_mem_busywait (mem_busywait),
    .o_state        (w_state),
    .o_count        (w_count)
  );

  // Hits resolve combinationally; memory strobes decode from the sequencer state.
  always_comb begin
    readdata      = '0;
    busywait      = !w_idle || w_miss;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    if (w_read_hit) readdata = r_data[w_addr.index][w_addr.offset];
    case (w_state)
      WB_ACCESS: begin
        mem_write     = 1'b1;
        mem_address   = block_addr(r_tag[w_addr.index], w_addr.index, w_count);
        mem_writedata = r_data[w_addr.index][w_count];
      end
      FILL_ACCESS: begin
        mem_read    = 1'b1;
        mem_address = block_addr(w_addr.tag, w_addr.index, w_count);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill_done) begin
      r_valid[w_addr.index] <= 1'b1;
      r_dirty[w_addr.index] <= 1'b0;
    end else if (w_write_hit) begin
      r_dirty[w_addr.index] <= 1'b1;
    end
  end

  // Data and tags carry no reset; valid bits alone gate their use.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_fill_we)   r_data[w_addr.index][w_count]       <= mem_readdata;
      if (w_write_hit) r_data[w_addr.index][w_addr.offset] <= writedata;
      if (w_fill_done) r_tag[w_addr.index]                 <= w_addr.tag;
    end
  end

endmodule
